farrow_horner: RTL
==================

# farrow_horner

Polynomial-evaluation back end of the Farrow fractional-delay resampler. Consumes the `polinom` parallel branch outputs of the Farrow FIR bank, together with a per-sample fractional delay `mu`, and evaluates y = (((c4·mu + c3)·mu + c2)·mu + c1)·mu + c0 with a fully pipelined Horner structure. The block accepts one sample set per clock and forwards `vld` and `last` sideband flags aligned with the result. It sits directly after the FIR bank and before output formatting.

## Interface
- `width_data_in`, 21: signed width of each branch coefficient c_k.
- `width_mu`, 16: unsigned width of `mu_in`. Value represents mu = mu_in / 2^width_mu, so mu is in [0, 1).
- `polinom`, 5: number of branches (polynomial order + 1). Legal range 2..8.
- `width_acc`, 24: internal and output width. Must be ≥ width_data_in + ceil(log2(polinom)).
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  asynchronous reset, active-low; clears all state.
- `data_in`  in  [width_data_in-1:0] × [polinom-1:0]  signed branch outputs; `data_in[k]` = c_k.
- `mu_in`  in  width_mu  fractional delay, sampled with `vld_in`.
- `vld_in`  in  1  input sample set valid.
- `last_in`  in  1  marks the last sample of a frame; meaningful only with `vld_in`.
- `data_out`  out  width_acc  signed result y.
- `vld_out`  out  1  result valid.
- `last_out`  out  1  `last` aligned with the result.

## Operation
- There is no backpressure. The pipeline advances every clock. Throughput is one result per clock.
- **Stage 0 (input register):**
  - acc0 = sign-extended c_{polinom-1}.
  - Registers mu, `last_in`, `vld_in` and c_0..c_{polinom-2}.
- **Stages 1..polinom-1 (Horner step j):**
  - Compute p = acc_{j-1} × {1'b0, mu}. This is a signed product of width_acc + width_mu + 1 bits.
  - Compute acc_j = (p >>> width_mu) + sign-extended c_{polinom-1-j}.
  - Carry the remaining coefficients and mu forward, each delayed by one stage.
- Shifts are arithmetic right shifts. Without rounding (see Configuration) they truncate toward −∞.
- Overflow cannot occur, because |y| ≤ Σ|c_k| and width_acc satisfies the growth rule above. No saturation logic is present.
- The `vld` and `last` shift registers run in parallel with the data. `last` is ANDed with `vld` at stage 0, so `last_out` is only ever asserted together with `vld_out`.
- Data registers of every stage load every cycle; invalid stages carry don't-care data.
- The `data_out` register loads only when its stage valid is 1. It therefore holds the last valid result while `vld_out` is 0.
- **Reset (asserted, rst = 0):**
  - `data_out` = 0, `vld_out` = 0, `last_out` = 0.
  - All stage registers and both flag shift registers are cleared immediately, without waiting for a clock.
- **Reset mid-stream:** in-flight samples are discarded; no partial frame is emitted after release.
- **Reset release:** the first `vld_in` accepted after release appears exactly `polinom` cycles later.

## Timing
- Latency: `vld_in` at rising edge t gives `vld_out` at edge t + polinom (5 with defaults).
- `data_out` and `last_out` have the same latency as `vld_out`.
- Back-to-back valid inputs produce back-to-back valid outputs. Gaps in `vld_in` are reproduced unchanged at the output.
- Every output comes directly from a flop; there are no combinational input-to-output paths.
- Critical path per stage: one width_acc × (width_mu+1) multiply, then one width_acc adder, then the rounding adder if enabled. Mapped to one DSP cascade per stage.

## Configuration
- Macro `FARROW_HORNER_ROUND_EN`.
- **Defined:** each Horner stage adds 2^(width_mu−1) to p before the shift (round half up).
- **Undefined:** plain truncation (floor), with no extra adder.
- Latency, interface and reset behaviour are identical in both builds.

## Test plan
All scenarios use defaults, with c_k = 0 unless stated.

1. **Zero delay.** c0=100, c1=c2=c3=c4=500, mu_in=0 → `data_out`=100 after exactly 5 cycles, with `vld_out` high for one cycle.
2. **Rounding.** c4=1000, mu_in=0x8000 → intermediate results 500, 250, 125, then 62.5 at the final stage.
   - Truncate build: 62.
   - Round build: 63.
   - Repeat with c4=−1000: truncate build −63, round build −62.
3. **Full scale.** All c_k = 1048575, mu_in=0xFFFF → positive result, no wrap, matches the bit-exact model. Then all c_k = −1048576 → negative result, matches the model.
4. **Streaming and gaps.** 64 consecutive valid sets with random c_k and mu, then a 3-cycle gap, then 10 more sets → output stream matches the model sample-for-sample, including the 3-cycle `vld_out` gap; `last_in` on the 64th set appears on the 64th `vld_out`.
5. **Last masking.** `last_in`=1 while `vld_in`=0 → `last_out` never asserts.
6. **Reset mid-stream.** Assert `rst`=0 for 2 cycles while 3 samples are in flight → outputs go to 0 asynchronously and none of the 3 samples emerges. After release, a new sample appears 5 cycles after its `vld_in`.

Source files
------------

// File: rtl/farrow_horner.sv
// Farrow resampler polynomial back end: pipelined Horner evaluation of
// y = sum c_k * mu^k. Define FARROW_HORNER_ROUND_EN for round-half-up steps.
module farrow_horner #(
    parameter int unsigned width_data_in = 21,
    parameter int unsigned width_mu      = 16,
    parameter int unsigned polinom       = 5,
    parameter int unsigned width_acc     = 24
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [polinom-1:0][width_data_in-1:0]   data_in,
    input  logic [width_mu-1:0]                     mu_in,
    input  logic                                    vld_in,
    input  logic                                    last_in,
    output logic [width_acc-1:0]                    data_out,
    output logic                                    vld_out,
    output logic                                    last_out
);

    localparam int unsigned PROD_W = width_acc + width_mu + 1;
    localparam int unsigned NCOEF  = polinom - 1;

    // Per-stage accumulator; stage polinom-1 holds the finished result.
    logic signed [width_acc-1:0]     acc_q  [polinom];
    logic signed [width_acc-1:0]     acc_d  [polinom];
    logic [width_mu-1:0]             mu_q   [NCOEF];
    logic [width_mu-1:0]             mu_d   [NCOEF];
    logic signed [width_data_in-1:0] coef_q [NCOEF][NCOEF];
    logic signed [width_data_in-1:0] coef_d [NCOEF][NCOEF];
    logic [polinom-1:0]              vld_q, vld_d;
    logic [polinom-1:0]              last_q, last_d;
    logic [width_acc-1:0]            data_out_q, data_out_d;
    logic                            vld_out_q, vld_out_d;
    logic                            last_out_q, last_out_d;

    // One Horner step: (acc * mu) >>> width_mu + coef, mu treated as unsigned.
    function automatic logic signed [width_acc-1:0] horner_step(
        input logic signed [width_acc-1:0]     acc,
        input logic [width_mu-1:0]             mu,
        input logic signed [width_data_in-1:0] coef
    );
        logic signed [width_mu:0]   mu_s;
        logic signed [PROD_W-1:0]   prod;
        mu_s = signed'({1'b0, mu});
        prod = PROD_W'(acc) * PROD_W'(mu_s);
`ifdef FARROW_HORNER_ROUND_EN
        prod = prod + signed'(PROD_W'(64'd1 << (width_mu - 1)));
`endif
        return width_acc'(prod >>> width_mu) + width_acc'(coef);
    endfunction

    always_comb begin
        acc_d      = '{default: '0};
        mu_d       = '{default: '0};
        coef_d     = '{default: '{default: '0}};
        vld_d      = '0;
        last_d     = '0;
        data_out_d = data_out_q;
        vld_out_d  = 1'b0;
        last_out_d = 1'b0;

        acc_d[0]  = width_acc'(signed'(data_in[polinom-1]));
        mu_d[0]   = mu_in;
        vld_d[0]  = vld_in;
        last_d[0] = last_in & vld_in;
        for (int k = 0; k < int'(NCOEF); k++) begin
            coef_d[0][k] = signed'(data_in[k]);
        end

        for (int j = 1; j < int'(polinom); j++) begin
            acc_d[j]  = horner_step(acc_q[j-1], mu_q[j-1], coef_q[j-1][int'(NCOEF) - j]);
            vld_d[j]  = vld_q[j-1];
            last_d[j] = last_q[j-1];
        end

        // Coefficients and mu ride along with their sample.
        for (int j = 1; j < int'(NCOEF); j++) begin
            mu_d[j] = mu_q[j-1];
            for (int k = 0; k < int'(NCOEF); k++) begin
                coef_d[j][k] = coef_q[j-1][k];
            end
        end

        if (vld_q[polinom-1]) begin
            data_out_d = acc_q[polinom-1];
        end
        vld_out_d  = vld_q[polinom-1];
        last_out_d = last_q[polinom-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q      <= '{default: '0};
            mu_q       <= '{default: '0};
            coef_q     <= '{default: '{default: '0}};
            vld_q      <= '0;
            last_q     <= '0;
            data_out_q <= '0;
            vld_out_q  <= 1'b0;
            last_out_q <= 1'b0;
        end else begin
            acc_q      <= acc_d;
            mu_q       <= mu_d;
            coef_q     <= coef_d;
            vld_q      <= vld_d;
            last_q     <= last_d;
            data_out_q <= data_out_d;
            vld_out_q  <= vld_out_d;
            last_out_q <= last_out_d;
        end
    end

    assign data_out = data_out_q;
    assign vld_out  = vld_out_q;
    assign last_out = last_out_q;

endmodule
